posi_ctrl_qt: RTL

//  Parametrised quad-tree scheduler for the post-intra stage. Per LCU it runs the
//  pre-transform, visits every CU from MIN to MAX size in z-order (Rmd/ref handshake

---
 rtl/posi_ctrl_qt.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/posi_ctrl_qt.sv
`default_nettype none
// ============================================================================
// Module   : posi_ctrl_qt
// Desc     : Post-intra quad-tree scheduler: pre-transform, z-order CU visits
//            with traversal counting and inter-subtree waits, decision, post-transform.
// Revision : 1.0 - initial release
// ============================================================================
module posi_ctrl_qt #(
    parameter int LCU_LOG2     = 6,
    parameter int MAX_LOG2     = 5,
    parameter int MIN_LOG2     = 2,
    parameter int PIX_PER_CYC  = 16,
    parameter int WAIT_SCALE   = 2,
    parameter bit TRA_MODE_PRE = 1'b0,
    parameter bit TRA_MODE_POS = 1'b1,
    localparam int POS_WD      = 2 * (LCU_LOG2 - MIN_LOG2),
    localparam int NLV         = MAX_LOG2 - MIN_LOG2 + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [2:0]        num_mode_i,
    input  logic [NLV-1:0]    size_en_i,
    input  logic              done_ref_i,
    input  logic              done_tra_i,
    input  logic              done_dec_i,
    output logic              start_tra_o,
    output logic              start_ref_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              tra_busy_o,
    output logic              tra_mode_o,
    output logic [2:0]        size_o,
    output logic [POS_WD-1:0] position_o
);

    localparam int C_PIX_LOG2 = $clog2(PIX_PER_CYC);
    localparam int C_TW       = 2 * MAX_LOG2;
    localparam int C_WW       = NLV + $clog2(WAIT_SCALE + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRA_PRE = 3'd1;
    localparam logic [2:0] S_PRED    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DECI    = 3'd4;
    localparam logic [2:0] S_TRA_POS = 3'd5;

    // Last traversal index for a level offset: max(1, 4^L/PIX_PER_CYC) - 1
    function automatic logic [C_TW-1:0] trav_last(input logic [2:0] lvl);
        int sh;
        sh = 2 * (MIN_LOG2 + int'(lvl)) - C_PIX_LOG2;
        if (sh <= 0) return '0;
        return C_TW'((1 << sh) - 1);
    endfunction

    function automatic logic [C_WW-1:0] wait_len(input logic [2:0] lvl);
        return C_WW'(((1 << int'(lvl)) - 1) * WAIT_SCALE);
    endfunction

    logic [2:0]        r_state, w_nstate;
    logic [2:0]        r_lvl, w_nlvl;
    logic [POS_WD-1:0] r_pos, w_npos, w_step;
    logic [1:0]        w_sub;
    logic [C_TW-1:0]   r_trav;
    logic [2:0]        r_mode;
    logic [C_WW-1:0]   r_wcnt, w_wait_load;
    logic              r_ref_lat, r_trav_lat, r_first;
    logic              r_start_tra, r_start_ref, r_done;
    logic              w_in_pred, w_lvl_en, w_nlvl_en, w_at_max;
    logic              w_trav_end, w_trav_done, w_done_cu, w_new_cu;

    assign w_in_pred   = (r_state == S_PRED);
    assign w_lvl_en    = |(size_en_i & (NLV'(1) << r_lvl));
    assign w_nlvl_en   = |(size_en_i & (NLV'(1) << w_nlvl));
    assign w_at_max    = (r_lvl == 3'(NLV - 1));
    assign w_sub       = 2'(r_pos >> (2 * r_lvl));
    assign w_step      = POS_WD'(1) << (2 * r_lvl);
    assign w_trav_end  = (r_trav == trav_last(r_lvl));
    assign w_trav_done = w_trav_end && (r_mode == num_mode_i);

    // A disabled size completes in the first cycle of its visit
    assign w_done_cu = w_in_pred &&
                       (w_lvl_en ? ((done_ref_i | r_ref_lat) & (w_trav_done | r_trav_lat))
                                 : r_first);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate    = r_state;
        w_npos      = r_pos;
        w_nlvl      = r_lvl;
        w_wait_load = '0;
        w_new_cu    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_nstate = S_TRA_PRE;
            end
            S_TRA_PRE: begin
                if (done_tra_i) begin
                    w_nstate = S_PRED;
                    w_new_cu = 1'b1;
                end
            end
            S_PRED: begin
                if (w_done_cu) begin
                    if (w_sub != 2'd3 && r_lvl == 3'd0) begin
                        w_npos   = r_pos + POS_WD'(1);
                        w_new_cu = 1'b1;
                    end else if (w_sub != 2'd3) begin
                        w_npos      = r_pos + w_step;
                        w_nlvl      = 3'd0;
                        w_wait_load = wait_len(r_lvl);
                        if (wait_len(r_lvl) == '0) begin
                            w_new_cu = 1'b1;
                        end else begin
                            w_nstate = S_WAIT;
                        end
                    end else if (!w_at_max) begin
                        w_npos   = r_pos - (w_step + (w_step << 1));
                        w_nlvl   = r_lvl + 3'd1;
                        w_new_cu = 1'b1;
                    end else begin
                        w_npos   = '0;
                        w_nlvl   = 3'd0;
                        w_nstate = S_DECI;
                    end
                end
            end
            S_WAIT: begin
                if (r_wcnt <= C_WW'(1)) begin
                    w_nstate = S_PRED;
                    w_new_cu = 1'b1;
                end
            end
            S_DECI: begin
                if (done_dec_i) w_nstate = S_TRA_POS;
            end
            S_TRA_POS: begin
                if (done_tra_i) w_nstate = S_IDLE;
            end
            default: w_nstate = S_IDLE;
        endcase
        if (abort_i) begin
            w_nstate    = S_IDLE;
            w_npos      = '0;
            w_nlvl      = 3'd0;
            w_wait_load = '0;
            w_new_cu    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pos       <= '0;
            r_lvl       <= 3'd0;
            r_trav      <= '0;
            r_mode      <= 3'd0;
            r_wcnt      <= '0;
            r_ref_lat   <= 1'b0;
            r_trav_lat  <= 1'b0;
            r_first     <= 1'b0;
            r_start_tra <= 1'b0;
            r_start_ref <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pos       <= w_npos;
            r_lvl       <= w_nlvl;
            r_first     <= w_new_cu;
            r_start_ref <= w_new_cu & w_nlvl_en;
            r_start_tra <= (w_nstate == S_TRA_PRE && r_state != S_TRA_PRE) ||
                           (w_nstate == S_TRA_POS && r_state != S_TRA_POS);
            r_done      <= (r_state == S_TRA_POS) && (w_nstate == S_IDLE) && !abort_i;

            if (abort_i || !w_in_pred || w_done_cu) begin
                r_trav     <= '0;
                r_mode     <= 3'd0;
                r_ref_lat  <= 1'b0;
                r_trav_lat <= 1'b0;
            end else begin
                if (w_trav_end) begin
                    r_trav <= '0;
                    r_mode <= (r_mode == num_mode_i) ? 3'd0 : r_mode + 3'd1;
                end else begin
                    r_trav <= r_trav + C_TW'(1);
                end
                r_ref_lat  <= r_ref_lat | (done_ref_i & w_lvl_en);
                r_trav_lat <= r_trav_lat | w_trav_done;
            end

            if (abort_i) begin
                r_wcnt <= '0;
            end else if (w_in_pred) begin
                r_wcnt <= w_wait_load;
            end else if (r_state == S_WAIT && r_wcnt != '0) begin
                r_wcnt <= r_wcnt - C_WW'(1);
            end
        end
    end

    always_comb begin
        busy_o     = (r_state != S_IDLE);
        tra_busy_o = (r_state == S_TRA_PRE) || (r_state == S_TRA_POS);
        tra_mode_o = (r_state == S_TRA_PRE) ? TRA_MODE_PRE : TRA_MODE_POS;
        size_o     = w_in_pred ? r_lvl : 3'd0;
    end

    assign position_o  = r_pos;
    assign start_tra_o = r_start_tra;
    assign start_ref_o = r_start_ref;
    assign done_o      = r_done;

endmodule
`default_nettype wire
